sym_fir_mac_sequencer: RTL and testbench

SYM_FIR_MAC_SEQUENCER -- requirements
Module: sym_fir_mac_sequencer

---
 rtl/sym_fir_pkg.sv | 18 +
 rtl/sym_fir_sample_buffer.sv | 47 ++++
 rtl/sym_fir_mac_sequencer.sv | 117 +++++++++++
 tb/tb_sym_fir_mac_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sym_fir_pkg.sv
`default_nettype none
// ============================================================================
// sym_fir_pkg : shared FSM state type and result-width helper  -- rev 1.0
// ============================================================================
package sym_fir_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  // Headroom covers N_COEFFS pre-added products each one bit wider than a sample.
  function automatic int out_word_size(input int in_w, input int coeff_w, input int n_coeffs);
    return in_w + coeff_w + $clog2(n_coeffs) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sym_fir_sample_buffer.sv
`default_nettype none
// ============================================================================
// sym_fir_sample_buffer : circular sample history, 1 write / 2 offset reads -- rev 1.0
// ============================================================================
module sym_fir_sample_buffer #(
  parameter  int WORD_SIZE = 16,
  parameter  int DEPTH     = 10,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic signed [WORD_SIZE-1:0] wr_data,
  input  logic        [AW-1:0]        off_a,
  input  logic        [AW-1:0]        off_b,
  output logic signed [WORD_SIZE-1:0] rd_a,
  output logic signed [WORD_SIZE-1:0] rd_b
);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X  = (AW + 1)'(DEPTH);

  logic signed [WORD_SIZE-1:0] mem [DEPTH];
  logic        [AW-1:0]        wr_ptr;

  // Offset 0 is the newest sample, which sits one slot behind the write pointer.
  function automatic logic [AW-1:0] slot(input logic [AW-1:0] ptr, input logic [AW-1:0] off);
    logic [AW:0] s;
    s = {1'b0, ptr} + {1'b0, PTR_LAST} - {1'b0, off};
    return (s >= DEPTH_X) ? AW'(s - DEPTH_X) : s[AW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
    end
  end

  assign rd_a = mem[slot(wr_ptr, off_a)];
  assign rd_b = mem[slot(wr_ptr, off_b)];

endmodule
`default_nettype wire

// File: rtl/sym_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// sym_fir_mac_sequencer : even-symmetric FIR on one time-shared pre-add MAC -- rev 1.0
// ============================================================================
module sym_fir_mac_sequencer
  import sym_fir_pkg::*;
#(
  parameter  int INPUT_WORD_SIZE = 16,
  parameter  int COEFF_WORD_SIZE = 16,
  parameter  int N_COEFFS        = 5,
  parameter  logic signed [N_COEFFS-1:0][COEFF_WORD_SIZE-1:0] COEFFS = '0,
  localparam int OUTPUT_WORD_SIZE = out_word_size(INPUT_WORD_SIZE, COEFF_WORD_SIZE, N_COEFFS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic signed [INPUT_WORD_SIZE-1:0]  data_in,
  input  logic                               valid_in,
  output logic                               ready_in,
  output logic signed [OUTPUT_WORD_SIZE-1:0] data_out,
  output logic                               valid_out,
  output logic                               busy
);

  localparam int DEPTH = 2 * N_COEFFS;
  localparam int AW    = $clog2(DEPTH);
  localparam int KW    = (N_COEFFS > 1) ? $clog2(N_COEFFS) : 1;
  localparam int PW    = INPUT_WORD_SIZE + 1;
  localparam int MW    = PW + COEFF_WORD_SIZE;
  localparam logic [KW-1:0] K_LAST     = KW'(N_COEFFS - 1);
  localparam logic [AW-1:0] OFF_MIRROR = AW'(DEPTH - 1);

  state_t                               state, state_next;
  logic        [KW-1:0]                 k, k_next;
  logic signed [OUTPUT_WORD_SIZE-1:0]   acc, acc_next, acc_sum, data_out_next;
  logic                                 valid_next, wr_en;
  logic        [AW-1:0]                 off_new, off_old;
  logic signed [INPUT_WORD_SIZE-1:0]    tap_new, tap_old;
  logic signed [PW-1:0]                 pre_sum;
  logic signed [COEFF_WORD_SIZE-1:0]    coeff;
  logic signed [MW-1:0]                 product;

  // Tap k pairs with its mirror 2N-1-k, so both share COEFFS[k].
  assign off_new = AW'(k);
  assign off_old = OFF_MIRROR - off_new;

  sym_fir_sample_buffer #(
    .WORD_SIZE (INPUT_WORD_SIZE),
    .DEPTH     (DEPTH)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (data_in),
    .off_a   (off_new),
    .off_b   (off_old),
    .rd_a    (tap_new),
    .rd_b    (tap_old)
  );

  assign coeff   = COEFFS[k];
  assign pre_sum = PW'(tap_new) + PW'(tap_old);
  assign product = coeff * pre_sum;
  assign acc_sum = acc + OUTPUT_WORD_SIZE'(product);

  always_comb begin
    state_next    = state;
    k_next        = k;
    acc_next      = acc;
    data_out_next = data_out;
    valid_next    = 1'b0;
    wr_en         = 1'b0;
    ready_in      = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        ready_in = 1'b1;
        if (valid_in) begin
          wr_en      = 1'b1;
          acc_next   = '0;
          k_next     = '0;
          state_next = MAC;
        end
      end
      MAC: begin
        busy = 1'b1;
        if (k == K_LAST) begin
          data_out_next = acc_sum;
          valid_next    = 1'b1;
          k_next        = '0;
          state_next    = IDLE;
        end else begin
          acc_next = acc_sum;
          k_next   = k + KW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      acc       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_next;
      k         <= k_next;
      acc       <= acc_next;
      data_out  <= data_out_next;
      valid_out <= valid_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sym_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// tb_sym_fir_mac_sequencer : directed vectors plus golden-model random run -- rev 1.0
// ============================================================================
module tb_sym_fir_mac_sequencer;

  localparam int N = 5;
  localparam logic signed [N-1:0][15:0] C_A = {16'sd5, 16'sd4, 16'sd3, 16'sd2, 16'sd1};
  localparam logic signed [N-1:0][15:0] C_N = {5{16'sh8000}};
  localparam logic signed [N-1:0][15:0] C_R = {-16'sd31457, 16'sd12345, -16'sd771, 16'sh7fff, 16'sh8000};

  logic clk = 1'b0;
  logic rst, valid_in;
  logic signed [15:0] data_in;
  logic signed [35:0] dout_a, dout_n, dout_r, dout_c;
  logic vo_a, vo_n, vo_r, rdy_a, rdy_n, rdy_r, bsy_a, bsy_n, bsy_r;
  logic valid_c, ready_c, busy_c;
  int   sel;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sym_fir_mac_sequencer #(.INPUT_WORD_SIZE(16), .COEFF_WORD_SIZE(16), .N_COEFFS(N), .COEFFS(C_A)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(rdy_a),
    .data_out(dout_a), .valid_out(vo_a), .busy(bsy_a));
  sym_fir_mac_sequencer #(.INPUT_WORD_SIZE(16), .COEFF_WORD_SIZE(16), .N_COEFFS(N), .COEFFS(C_N)) dut_n (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(rdy_n),
    .data_out(dout_n), .valid_out(vo_n), .busy(bsy_n));
  sym_fir_mac_sequencer #(.INPUT_WORD_SIZE(16), .COEFF_WORD_SIZE(16), .N_COEFFS(N), .COEFFS(C_R)) dut_r (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(rdy_r),
    .data_out(dout_r), .valid_out(vo_r), .busy(bsy_r));

  always_comb begin
    dout_c = dout_a; valid_c = vo_a; ready_c = rdy_a; busy_c = bsy_a;
    case (sel)
      1: begin dout_c = dout_n; valid_c = vo_n; ready_c = rdy_n; busy_c = bsy_n; end
      2: begin dout_c = dout_r; valid_c = vo_r; ready_c = rdy_r; busy_c = bsy_r; end
      default: ;
    endcase
  end

  typedef struct {
    logic signed [15:0] din;
    longint             exp;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0; data_in = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One sample through the handshake, then latency, result and ready checks.
  task automatic apply(input logic signed [15:0] din, input longint exp, input string tag);
    int cnt;
    check($sformatf("%s.ready", tag), longint'(ready_c), 1);
    data_in = din; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check($sformatf("%s.busy", tag), longint'(busy_c), 1);
    cnt = 0;
    while (!valid_c && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check($sformatf("%s.latency", tag), cnt, N);
    check($sformatf("%s.data", tag), longint'(dout_c), exp);
    check($sformatf("%s.ready_back", tag), longint'(ready_c), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   tbl[23];
    longint cr[N];
    longint hist[2*N];
    longint y;
    int     na, nv, seen;
    logic signed [15:0] x;

    tbl = '{'{16'sd1, 1}, '{16'sd0, 2}, '{16'sd0, 3}, '{16'sd0, 4}, '{16'sd0, 5}, '{16'sd0, 5},
            '{16'sd0, 4}, '{16'sd0, 3}, '{16'sd0, 2}, '{16'sd0, 1}, '{16'sd0, 0},
            '{16'sd100, 100}, '{16'sd100, 300}, '{16'sd100, 600}, '{16'sd100, 1000},
            '{16'sd100, 1500}, '{16'sd100, 2000}, '{16'sd100, 2400}, '{16'sd100, 2700},
            '{16'sd100, 2900}, '{16'sd100, 3000}, '{16'sd100, 3000}, '{16'sd100, 3000}};
    for (int i = 0; i < N; i++) cr[i] = longint'($signed(C_R[i]));

    sel = 0;
    rst = 1'b1; valid_in = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset.ready", longint'(ready_c), 1);
    check("reset.busy", longint'(busy_c), 0);
    check("reset.valid", longint'(valid_c), 0);
    check("reset.data", longint'(dout_c), 0);

    // Impulse response then step to steady state
    for (int i = 0; i < 23; i++) apply(tbl[i].din, tbl[i].exp, $sformatf("vec%0d", i));
    @(posedge clk); #1;
    check("strobe_once", longint'(valid_c), 0);
    check("data_hold", longint'(dout_c), 3000);

    // valid_in held high: accepts and results every N+1 cycles
    do_reset();
    data_in = 16'sd1; valid_in = 1'b1; na = 0; nv = 0;
    for (int c = 0; c <= 30; c++) begin
      if (valid_c) begin
        check($sformatf("cont.valid_cycle%0d", nv), c, 6 * (nv + 1));
        if (nv < 5) check($sformatf("cont.data%0d", nv), longint'(dout_c), longint'(nv + 1));
        nv++;
      end
      if (ready_c) begin
        check($sformatf("cont.accept_cycle%0d", na), c, 6 * na);
        na++;
      end
      @(posedge clk); #1;
      if (na > 0) data_in = '0;
    end
    valid_in = 1'b0;
    check("cont.accepts", na, 6);
    check("cont.results", nv, 5);

    // Reset in the third MAC cycle discards the result and the history
    do_reset();
    apply(16'sd7, 7, "pre0");
    apply(16'sd7, 21, "pre1");
    data_in = 16'sd9; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst.ready", longint'(ready_c), 1);
    check("midrst.busy", longint'(busy_c), 0);
    check("midrst.data", longint'(dout_c), 0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (valid_c) seen++;
      @(posedge clk); #1;
    end
    check("midrst.no_valid", seen, 0);
    for (int i = 0; i < 11; i++) apply(tbl[i].din, tbl[i].exp, $sformatf("post%0d", i));

    // Full-scale negative samples and coefficients
    sel = 1;
    do_reset();
    for (int i = 1; i <= 10; i++) apply(-16'sd32768, longint'(i) <<< 30, $sformatf("neg%0d", i));

    // Random samples against a direct-form golden model
    sel = 2;
    do_reset();
    for (int j = 0; j < 2*N; j++) hist[j] = 0;
    for (int n = 0; n < 10000; n++) begin
      x = 16'($urandom);
      for (int j = 2*N-1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = longint'(x);
      y = 0;
      for (int k = 0; k < N; k++) y += cr[k] * (hist[k] + hist[2*N-1-k]);
      apply(x, y, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
